// File: rtl/z_result_collector.sv
// z_result_collector: captures strobed z_out results into an m x m buffer,
// then drains the full matrix row-major over a valid/ready port once the
// multiplier signals done. Sticky flags report producer protocol errors.
module z_result_collector #(
  parameter int m  = 4,
  parameter int IW = $clog2(m)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [31:0]   z_out,
  input  logic [IW-1:0] z_i,
  input  logic [IW-1:0] z_j,
  input  logic          z_stb,
  input  logic          done,
  output logic [31:0]   r_data,
  output logic [IW-1:0] r_i,
  output logic [IW-1:0] r_j,
  output logic          r_valid,
  input  logic          r_ready,
  output logic          r_last,
  output logic          busy,
  output logic          err_missing,
  output logic          err_dup,
  output logic          err_overrun
);

  localparam int N  = m * m;
  localparam int AW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {COLLECT, DRAIN} state_t;

  state_t          r_state;
  logic [31:0]     r_buf [N];
  logic [N-1:0]    r_mask;
  logic [IW-1:0]   r_row;
  logic [IW-1:0]   r_col;
  logic            r_err_missing;
  logic            r_err_dup;
  logic            r_err_overrun;

  logic            w_in_range;
  logic [AW-1:0]   w_wr_idx;
  logic [AW-1:0]   w_rd_idx;
  logic [N-1:0]    w_onehot;
  logic            w_set;
  logic            w_hit;
  logic [N-1:0]    w_mask_upd;
  logic            w_at_end;

  // When m is a power of two every index value is a real cell; otherwise
  // indices past m-1 must be rejected.
  generate
    if (m == (1 << IW)) begin : g_pow2
      assign w_in_range = 1'b1;
    end else begin : g_npow2
      assign w_in_range = (z_i < IW'(m)) && (z_j < IW'(m));
    end
  endgenerate

  // Write-side address decode and written-mask update
  always_comb begin
    w_wr_idx   = AW'(z_i) * AW'(m) + AW'(z_j);
    w_rd_idx   = AW'(r_row) * AW'(m) + AW'(r_col);
    w_set      = z_stb && w_in_range;
    w_onehot   = w_set ? (N'(1) << w_wr_idx) : '0;
    w_hit      = |(r_mask & w_onehot);
    w_mask_upd = r_mask | w_onehot;
    w_at_end   = (r_row == IW'(m - 1)) && (r_col == IW'(m - 1));
  end

  // Drain port outputs come straight from state, pointer and buffer
  always_comb begin
    r_valid     = (r_state == DRAIN);
    busy        = r_valid;
    r_i         = r_row;
    r_j         = r_col;
    r_last      = r_valid && w_at_end;
    r_data      = r_valid ? r_buf[w_rd_idx] : 32'h0;
    err_missing = r_err_missing;
    err_dup     = r_err_dup;
    err_overrun = r_err_overrun;
  end

  // Collect/drain state machine, buffer writes and sticky error flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= COLLECT;
      r_mask        <= '0;
      r_row         <= '0;
      r_col         <= '0;
      r_err_missing <= 1'b0;
      r_err_dup     <= 1'b0;
      r_err_overrun <= 1'b0;
      for (int k = 0; k < N; k++) r_buf[k] <= 32'h0;
    end else begin
      case (r_state)
        COLLECT: begin
          if (w_set) r_buf[w_wr_idx] <= z_out;
          r_mask <= w_mask_upd;
          // Out-of-range indices and rewrites of a cell are both duplicates
          if (z_stb && (!w_in_range || w_hit)) r_err_dup <= 1'b1;
          // Same-cycle strobe counts toward completeness via w_mask_upd
          if (done) begin
            r_state <= DRAIN;
            if (!(&w_mask_upd)) r_err_missing <= 1'b1;
          end
        end
        DRAIN: begin
          if (z_stb) r_err_overrun <= 1'b1;
          if (r_ready) begin
            if (w_at_end) begin
              r_state <= COLLECT;
              r_mask  <= '0;
              r_row   <= '0;
              r_col   <= '0;
            end else if (r_col == IW'(m - 1)) begin
              r_col <= '0;
              r_row <= r_row + IW'(1);
            end else begin
              r_col <= r_col + IW'(1);
            end
          end
        end
        default: r_state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_z_result_collector.sv
// Directed bench for z_result_collector (m=4): fills, drains, backpressure,
// error flags and asynchronous reset during a drain.
module tb_z_result_collector;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] z_out = '0;
  logic [1:0]  z_i = '0;
  logic [1:0]  z_j = '0;
  logic        z_stb = 1'b0;
  logic        done = 1'b0;
  logic [31:0] r_data;
  logic [1:0]  r_i;
  logic [1:0]  r_j;
  logic        r_valid;
  logic        r_ready = 1'b0;
  logic        r_last;
  logic        busy;
  logic        err_missing;
  logic        err_dup;
  logic        err_overrun;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] d_data  [16];
  logic [1:0]  d_i     [16];
  logic [1:0]  d_j     [16];
  logic        d_last  [16];
  logic        d_valid [16];

  z_result_collector #(.m(4)) dut (
    .clk(clk), .rst(rst), .z_out(z_out), .z_i(z_i), .z_j(z_j),
    .z_stb(z_stb), .done(done), .r_data(r_data), .r_i(r_i), .r_j(r_j),
    .r_valid(r_valid), .r_ready(r_ready), .r_last(r_last), .busy(busy),
    .err_missing(err_missing), .err_dup(err_dup), .err_overrun(err_overrun)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1ns after each rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int i, input int j, input logic [31:0] v);
    z_stb = 1'b1; z_i = 2'(i); z_j = 2'(j); z_out = v;
    tick();
    z_stb = 1'b0;
  endtask

  task automatic pulse_done();
    done = 1'b1;
    tick();
    done = 1'b0;
  endtask

  // Records 16 consecutive cycles with r_ready held high
  task automatic drain_all();
    r_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      d_data[k] = r_data; d_i[k] = r_i; d_j[k] = r_j;
      d_last[k] = r_last; d_valid[k] = r_valid;
      tick();
    end
    r_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    n_vec++;
    if ({r_valid, r_last, busy, err_missing, err_dup, err_overrun} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_flags got %b exp 000000",
               {r_valid, r_last, busy, err_missing, err_dup, err_overrun});
    end
    n_vec++;
    if ({r_data, r_i, r_j} !== 36'h0) begin
      n_err++;
      $display("FAIL reset_data got %h/%0d/%0d exp 0/0/0", r_data, r_i, r_j);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_full_fill();
    for (int k = 0; k < 16; k++) wr(k / 4, k % 4, 32'h100 + k);
    pulse_done();
    n_vec++;
    if (r_valid !== 1'b1 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL full_start got valid=%b busy=%b exp 1/1", r_valid, busy);
    end
    drain_all();
    for (int k = 0; k < 16; k++) begin
      n_vec++;
      if (d_valid[k] !== 1'b1 || d_data[k] !== 32'h100 + k || d_i[k] !== 2'(k / 4) ||
          d_j[k] !== 2'(k % 4) || d_last[k] !== (k == 15)) begin
        n_err++;
        $display("FAIL full_beat[%0d] got v=%b d=%h i=%0d j=%0d l=%b exp v=1 d=%h i=%0d j=%0d l=%b",
                 k, d_valid[k], d_data[k], d_i[k], d_j[k], d_last[k],
                 32'h100 + k, k / 4, k % 4, (k == 15));
      end
    end
    n_vec++;
    if (r_valid !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL full_end got valid=%b busy=%b exp 0/0", r_valid, busy);
    end
    n_vec++;
    if ({err_missing, err_dup, err_overrun} !== 3'b0) begin
      n_err++;
      $display("FAIL full_errs got %b exp 000", {err_missing, err_dup, err_overrun});
    end
  endtask

  task automatic test_backpressure();
    int beat;
    beat = 0;
    for (int k = 15; k >= 0; k--) wr(k / 4, k % 4, 32'h200 + k);
    pulse_done();
    for (int c = 0; c < 100 && beat < 16; c++) begin
      r_ready = (c % 4 == 0) || (c % 4 == 3);
      n_vec++;
      if (r_valid !== 1'b1 || r_data !== 32'h200 + beat || r_i !== 2'(beat / 4) ||
          r_j !== 2'(beat % 4) || r_last !== (beat == 15)) begin
        n_err++;
        $display("FAIL bp_cycle[%0d] got v=%b d=%h i=%0d j=%0d l=%b exp v=1 d=%h i=%0d j=%0d",
                 c, r_valid, r_data, r_i, r_j, r_last, 32'h200 + beat, beat / 4, beat % 4);
      end
      if (r_ready) beat++;
      tick();
    end
    r_ready = 1'b0;
    n_vec++;
    if (beat != 16 || r_valid !== 1'b0) begin
      n_err++;
      $display("FAIL bp_end got beats=%0d valid=%b exp 16/0", beat, r_valid);
    end
  endtask

  task automatic test_same_cycle();
    for (int k = 0; k < 15; k++) wr(k / 4, k % 4, 32'h400 + k);
    z_stb = 1'b1; z_i = 2'd3; z_j = 2'd3; z_out = 32'hDEADBEEF; done = 1'b1;
    tick();
    z_stb = 1'b0; done = 1'b0;
    n_vec++;
    if (r_valid !== 1'b1 || err_missing !== 1'b0) begin
      n_err++;
      $display("FAIL same_start got valid=%b missing=%b exp 1/0", r_valid, err_missing);
    end
    drain_all();
    n_vec++;
    if (d_data[15] !== 32'hDEADBEEF || d_last[15] !== 1'b1) begin
      n_err++;
      $display("FAIL same_last got %h l=%b exp deadbeef l=1", d_data[15], d_last[15]);
    end
    n_vec++;
    if (d_data[0] !== 32'h400) begin
      n_err++;
      $display("FAIL same_first got %h exp 00000400", d_data[0]);
    end
  endtask

  task automatic test_err_dup();
    for (int k = 0; k < 16; k++) wr(k / 4, k % 4, 32'h500 + k);
    n_vec++;
    if (err_dup !== 1'b0) begin
      n_err++;
      $display("FAIL dup_before got %b exp 0", err_dup);
    end
    wr(1, 2, 32'h5FF);
    n_vec++;
    if (err_dup !== 1'b1) begin
      n_err++;
      $display("FAIL dup_flag got %b exp 1", err_dup);
    end
    pulse_done();
    drain_all();
    n_vec++;
    if (d_data[6] !== 32'h5FF || d_data[5] !== 32'h505) begin
      n_err++;
      $display("FAIL dup_data got %h/%h exp 000005ff/00000505", d_data[6], d_data[5]);
    end
    n_vec++;
    if (err_missing !== 1'b0) begin
      n_err++;
      $display("FAIL dup_missing got %b exp 0", err_missing);
    end
  endtask

  task automatic test_err_missing();
    for (int k = 1; k < 16; k++) wr(k / 4, k % 4, 32'h600 + k);
    pulse_done();
    n_vec++;
    if (err_missing !== 1'b1) begin
      n_err++;
      $display("FAIL missing_flag got %b exp 1", err_missing);
    end
    drain_all();
    n_vec++;
    if (d_data[0] !== 32'h500 || d_data[1] !== 32'h601) begin
      n_err++;
      $display("FAIL missing_stale got %h/%h exp 00000500/00000601", d_data[0], d_data[1]);
    end
  endtask

  task automatic test_overrun();
    pulse_done();
    r_ready = 1'b0;
    n_vec++;
    if (err_overrun !== 1'b0) begin
      n_err++;
      $display("FAIL overrun_before got %b exp 0", err_overrun);
    end
    wr(0, 0, 32'h00000BAD);
    n_vec++;
    if (err_overrun !== 1'b1 || r_data !== 32'h500 || r_i !== 2'd0 || r_j !== 2'd0) begin
      n_err++;
      $display("FAIL overrun_flag got f=%b d=%h i=%0d j=%0d exp 1/00000500/0/0",
               err_overrun, r_data, r_i, r_j);
    end
    drain_all();
    n_vec++;
    if (d_data[0] !== 32'h500 || d_data[15] !== 32'h60F || r_valid !== 1'b0) begin
      n_err++;
      $display("FAIL overrun_buf got %h/%h v=%b exp 00000500/0000060f v=0",
               d_data[0], d_data[15], r_valid);
    end
  endtask

  task automatic test_reset_mid_drain();
    for (int k = 0; k < 16; k++) wr(k / 4, k % 4, 32'h700 + k);
    pulse_done();
    r_ready = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    r_ready = 1'b0;
    n_vec++;
    if (r_data !== 32'h704 || r_i !== 2'd1 || r_j !== 2'd0) begin
      n_err++;
      $display("FAIL rstmid_beat5 got %h %0d/%0d exp 00000704 1/0", r_data, r_i, r_j);
    end
    rst = 1'b1;
    #1;
    n_vec++;
    if ({r_valid, busy, r_last, err_missing, err_dup, err_overrun} !== 6'b0 ||
        r_data !== 32'h0) begin
      n_err++;
      $display("FAIL rstmid_async got flags=%b d=%h exp 000000/0",
               {r_valid, busy, r_last, err_missing, err_dup, err_overrun}, r_data);
    end
    #2 rst = 1'b0;
    tick();
    for (int k = 0; k < 16; k++) wr(k / 4, k % 4, 32'hA5A5A5A5);
    pulse_done();
    drain_all();
    for (int k = 0; k < 16; k++) begin
      n_vec++;
      if (d_valid[k] !== 1'b1 || d_data[k] !== 32'hA5A5A5A5 || d_i[k] !== 2'(k / 4) ||
          d_j[k] !== 2'(k % 4)) begin
        n_err++;
        $display("FAIL rstmid_beat[%0d] got v=%b d=%h i=%0d j=%0d exp v=1 d=a5a5a5a5 i=%0d j=%0d",
                 k, d_valid[k], d_data[k], d_i[k], d_j[k], k / 4, k % 4);
      end
    end
    n_vec++;
    if ({err_missing, err_dup, err_overrun} !== 3'b0 || r_valid !== 1'b0) begin
      n_err++;
      $display("FAIL rstmid_end got errs=%b v=%b exp 000/0",
               {err_missing, err_dup, err_overrun}, r_valid);
    end
  endtask

  initial begin
    test_reset();
    test_full_fill();
    test_backpressure();
    test_same_cycle();
    test_err_dup();
    test_err_missing();
    test_overrun();
    test_reset_mid_drain();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
